bus_requester: RTL and testbench

Master-side front end for the shared multi-master bus. A local core pushes write/read beats into a small command FIFO. The block raises `bus_req` to the bus arbiter, waits for `bus_grant`, then drives `addr_m`/`wd_m`/`we_m` one beat per granted cycle. It holds `bus_lock` while further beats are queued, and flags grant-wait timeouts. One instance sits between each master and its arbiter port.

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_requester_if.sv | 28 ++
 rtl/bus_requester_sync_fifo.sv | 50 +++++
 rtl/bus_requester.sv | 89 ++++++++
 tb/tb_bus_requester.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus requester front end.
package bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic              we;
    } bus_cmd_t;

    localparam int CMD_W = $bits(bus_cmd_t);

    typedef enum logic [1:0] {IDLE, REQ, XFER} req_state_e;
endpackage

// File: rtl/bus_requester_if.sv
// Core command port plus arbiter/bus signals of one requester.
interface bus_requester_if;
    import bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wd;
    logic              cmd_we;
    logic              bus_req;
    logic              bus_lock;
    logic              bus_grant;
    logic [ADDR_W-1:0] addr_m;
    logic [DATA_W-1:0] wd_m;
    logic              we_m;
    logic              busy;
    logic              tmo_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wd, cmd_we, bus_grant,
        output cmd_ready, bus_req, bus_lock, addr_m, wd_m, we_m, busy, tmo_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wd, cmd_we, bus_grant,
        input  cmd_ready, bus_req, bus_lock, addr_m, wd_m, we_m, busy, tmo_err
    );
endinterface

// File: rtl/bus_requester_sync_fifo.sv
// Small synchronous FIFO; head is visible combinationally on o_rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full blocks a push even when a pop happens on the same edge.
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/bus_requester.sv
// Master-side bus front end: queues core beats, requests the bus and
// drives one beat per granted XFER cycle, with a grant-wait timeout.
module bus_requester
    import bus_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 256
) (
    input logic             clk,
    input logic             rstn,
    bus_requester_if.master bif
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);

    req_state_e    r_state;
    req_state_e    w_next;
    logic [TW-1:0] r_wcnt;
    bus_cmd_t      w_in;
    bus_cmd_t      w_head;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic          w_push;
    logic          w_pop;
    logic          w_tmo_hit;

    assign w_in      = '{addr: bif.cmd_addr, wd: bif.cmd_wd, we: bif.cmd_we};
    assign w_push    = bif.cmd_valid & ~w_full;
    assign w_pop     = (r_state == XFER) & bif.bus_grant;
    assign w_tmo_hit = (TMO_CYC != 0) && (r_state == REQ) && (r_wcnt == TMO_LAST);

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (!w_empty) w_next = REQ;
            REQ:  if (bif.bus_grant) w_next = XFER;
            // Last beat leaves unless a new beat lands on the same edge.
            XFER: begin
                if (!bif.bus_grant)                     w_next = REQ;
                else if (w_count == CNT_ONE && !w_push) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Wait counter only runs while staying in REQ; it wraps on each timeout.
    always_ff @(posedge clk) begin
        if (!rstn)                                r_wcnt <= '0;
        else if (r_state == REQ && w_next == REQ) r_wcnt <= w_tmo_hit ? '0 : r_wcnt + 1'b1;
        else                                      r_wcnt <= '0;
    end

    always_comb begin
        bif.cmd_ready = ~w_full;
        bif.bus_req   = (r_state != IDLE);
        bif.busy      = (r_state != IDLE);
        bif.bus_lock  = (r_state != IDLE) && (w_count >= CNT_TWO);
        bif.tmo_err   = w_tmo_hit;
        bif.addr_m    = '0;
        bif.wd_m      = '0;
        bif.we_m      = 1'b0;
        if (r_state == XFER) begin
            bif.addr_m = w_head.addr;
            bif.wd_m   = w_head.wd;
            bif.we_m   = w_head.we;
        end
    end
endmodule

// File: tb/tb_bus_requester.sv
// Cycle-table bench for bus_requester (DEPTH=4, TMO_CYC=8).
module tb_bus_requester;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_requester_if bif();

    bus_requester #(.DEPTH(4), .TMO_CYC(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bif  (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic        v;
        logic [31:0] a;
        logic [31:0] w;
        logic        we;
        logic        g;
        logic [69:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected bundle: {cmd_ready, bus_req, bus_lock, addr_m, wd_m, we_m, busy, tmo_err}
    function automatic vec_t mk(int rs, int v, int a, int w, int we, int g,
                                int rdy, int bsy, int lk, int am, int wm, int wem, int tmo);
        vec_t t;
        t.rs  = rs[0];
        t.v   = v[0];
        t.a   = 32'(a);
        t.w   = 32'(w);
        t.we  = we[0];
        t.g   = g[0];
        t.exp = {rdy[0], bsy[0], lk[0], 32'(am), 32'(wm), wem[0], bsy[0], tmo[0]};
        return t;
    endfunction

    task automatic add(int rs, int v, int a, int w, int we, int g,
                       int rdy, int bsy, int lk, int am, int wm, int wem, int tmo);
        vecs.push_back(mk(rs, v, a, w, we, g, rdy, bsy, lk, am, wm, wem, tmo));
    endtask

    // Drive one cycle's inputs, check outputs for that cycle, let the edge consume them.
    task automatic step(input vec_t t, input string nm);
        logic [69:0] act;
        @(negedge clk);
        rstn          = t.rs;
        bif.cmd_valid = t.v;
        bif.cmd_addr  = t.a;
        bif.cmd_wd    = t.w;
        bif.cmd_we    = t.we;
        bif.bus_grant = t.g;
        #1;
        act = {bif.cmd_ready, bif.bus_req, bif.bus_lock, bif.addr_m, bif.wd_m,
               bif.we_m, bif.busy, bif.tmo_err};
        n_cmp++;
        if (act !== t.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, t.exp);
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_wd    = '0;
        bif.cmd_we    = 1'b0;
        bif.bus_grant = 1'b0;
        repeat (2) @(posedge clk);

        // single write, grant one cycle after req
        add(1,1,'h10,'hA5,1,0, 1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,       1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,       1,1,0,0,0,0,0);
        add(1,0,0,0,0,1,       1,1,0,0,0,0,0);
        add(1,0,0,0,0,1,       1,1,0,'h10,'hA5,1,0);
        add(1,0,0,0,0,0,       1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,       1,0,0,0,0,0,0);
        // fill to DEPTH, 5th push rejected, 4 beats under continuous grant
        add(1,1,'h100,1,1,0,   1,0,0,0,0,0,0);
        add(1,1,'h104,2,0,0,   1,0,0,0,0,0,0);
        add(1,1,'h108,3,1,0,   1,1,1,0,0,0,0);
        add(1,1,'h10C,4,1,0,   1,1,1,0,0,0,0);
        add(1,1,'h110,5,1,1,   0,1,1,0,0,0,0);
        add(1,1,'h110,5,1,1,   0,1,1,'h100,1,1,0);
        add(1,0,0,0,0,1,       1,1,1,'h104,2,0,0);
        add(1,0,0,0,0,1,       1,1,1,'h108,3,1,0);
        add(1,0,0,0,0,1,       1,1,0,'h10C,4,1,0);
        add(1,0,0,0,0,0,       1,0,0,0,0,0,0);
        // grant dropped after beat 2 for 3 cycles, beat 3 retried
        add(1,1,'h200,'h11,1,0, 1,0,0,0,0,0,0);
        add(1,1,'h204,'h12,1,0, 1,0,0,0,0,0,0);
        add(1,1,'h208,'h13,1,0, 1,1,1,0,0,0,0);
        add(1,1,'h20C,'h14,0,1, 1,1,1,0,0,0,0);
        add(1,0,0,0,0,1,        0,1,1,'h200,'h11,1,0);
        add(1,0,0,0,0,1,        1,1,1,'h204,'h12,1,0);
        add(1,0,0,0,0,0,        1,1,1,'h208,'h13,1,0);
        add(1,0,0,0,0,0,        1,1,1,0,0,0,0);
        add(1,0,0,0,0,0,        1,1,1,0,0,0,0);
        add(1,0,0,0,0,1,        1,1,1,0,0,0,0);
        add(1,0,0,0,0,1,        1,1,1,'h208,'h13,1,0);
        add(1,0,0,0,0,1,        1,1,0,'h20C,'h14,0,0);
        add(1,0,0,0,0,0,        1,0,0,0,0,0,0);
        // push while popping at count=2, then on the emptying edge
        add(1,1,'h300,'h21,1,0, 1,0,0,0,0,0,0);
        add(1,1,'h304,'h22,1,0, 1,0,0,0,0,0,0);
        add(1,0,0,0,0,1,        1,1,1,0,0,0,0);
        add(1,1,'h308,'h23,1,1, 1,1,1,'h300,'h21,1,0);
        add(1,0,0,0,0,1,        1,1,1,'h304,'h22,1,0);
        add(1,1,'h30C,'h24,0,1, 1,1,0,'h308,'h23,1,0);
        add(1,0,0,0,0,1,        1,1,0,'h30C,'h24,0,0);
        add(1,0,0,0,0,0,        1,0,0,0,0,0,0);
        // grant withheld: tmo_err on REQ cycles 8 and 16
        add(1,1,'h400,'h31,1,0, 1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,        1,0,0,0,0,0,0);
        for (int k = 1; k <= 17; k++)
            add(1,0,0,0,0,0,    1,1,0,0,0,0, (k == 8 || k == 16) ? 1 : 0);
        add(1,0,0,0,0,1,        1,1,0,0,0,0,0);
        add(1,0,0,0,0,1,        1,1,0,'h400,'h31,1,0);
        add(1,0,0,0,0,0,        1,0,0,0,0,0,0);

        step(mk(1,0,0,0,0,0, 1,0,0,0,0,0,0), "reset_state");
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("row%0d", i));

        // reset mid-burst with 3 beats queued; nothing may come out afterwards
        step(mk(1,1,'h500,'h41,1,0, 1,0,0,0,0,0,0), "mrst_push0");
        step(mk(1,1,'h504,'h42,1,0, 1,0,0,0,0,0,0), "mrst_push1");
        step(mk(1,1,'h508,'h43,1,0, 1,1,1,0,0,0,0), "mrst_push2");
        step(mk(1,1,'h50C,'h44,1,1, 1,1,1,0,0,0,0), "mrst_push3");
        step(mk(1,0,0,0,0,1,        0,1,1,'h500,'h41,1,0), "mrst_xfer");
        step(mk(0,0,0,0,0,1,        1,1,1,'h504,'h42,1,0), "mrst_assert");
        for (int k = 0; k < 4; k++)
            step(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0), $sformatf("mrst_after%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
